// File: rtl/countdown_timer.sv
// Loadable down-counting timer with borrow-out, one-cycle terminal pulse and sticky expired flag.
// Optional COUNTDOWN_AUTO_RELOAD_EN: reload on expiry and keep running (free-running divider).
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             bos,
    output logic             tc,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic             tc_q;
    logic             expired_q;
    logic             last_step;

    // The enabled step that takes the count from 1 to 0; also the borrow-out.
    assign last_step = (state_q == RUN) && en && (count_q == WIDTH'(1));
    assign count_d   = count_q - WIDTH'(1);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            tc_q      <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (load) begin
                count_q  <= load_val;
                reload_q <= load_val;
                if (load_val != '0) begin
                    state_q   <= RUN;
                    expired_q <= 1'b0;
                end else begin
                    state_q   <= EXPIRED;
                    expired_q <= 1'b1;
                    tc_q      <= 1'b1;
                end
            end else begin
                case (state_q)
                    RUN: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (ack) begin
                            expired_q <= 1'b0;
                        end else if (last_step) begin
                            expired_q <= 1'b1;
                        end
                        if (last_step) begin
                            tc_q <= 1'b1;
                            if (reload_q != '0) begin
                                count_q <= reload_q;
                            end else begin
                                count_q   <= '0;
                                state_q   <= EXPIRED;
                                expired_q <= 1'b1;
                            end
                        end else if (en) begin
                            count_q <= count_d;
                        end
`else
                        if (last_step) begin
                            tc_q      <= 1'b1;
                            expired_q <= 1'b1;
                            count_q   <= '0;
                            state_q   <= EXPIRED;
                        end else if (en) begin
                            count_q <= count_d;
                        end
`endif
                    end
                    EXPIRED: begin
                        if (ack) begin
                            state_q   <= IDLE;
                            expired_q <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign count   = count_q;
    assign busy    = (state_q == RUN);
    assign bos     = last_step;
    assign tc      = tc_q;
    assign expired = expired_q;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counting timer; the counterpart of the team's enable-cascaded up-counter.
- Loaded with a start value, it decrements on each enabled clock and signals expiry with a borrow-out, a terminal pulse and a sticky expired flag.
- Acts as the programmable timeout/divider element in the datapath.
- Its borrow-out `bos` can drive the `en` input of a following stage.

Parameters:
- WIDTH, 4, bit width of count, load_val and reload register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-high reset.
- en  input  1  count enable / borrow-in; decrement happens only when en=1 in RUN.
- load  input  1  load strobe: captures load_val and starts the timer.
- load_val  input  WIDTH  start value sampled when load=1.
- ack  input  1  clears the expired flag and returns the timer from EXPIRED to IDLE.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  1 while the state is RUN.
- bos  output  1  combinational borrow-out: state==RUN and en=1 and count==1.
- tc  output  1  registered one-cycle pulse in the cycle after count reaches 0.
- expired  output  1  sticky expiry flag; cleared by ack or load.

Behaviour:
- Interface: one clock, clk. Reset clr is asynchronous and active-high.
- Reset (clr=1, any time including mid-count):
  - state=IDLE; count=0; reload register=0.
  - tc=0, expired=0, busy=0.
  - bos=0, because state is not RUN.
- Registers: state, count[WIDTH-1:0], reload[WIDTH-1:0], tc, expired. bos is combinational; busy decodes state.
- Priority every cycle: clr > load > ack > en.
- Load in any state:
  - count<=load_val; reload<=load_val; expired<=0.
  - If load_val!=0: next state=RUN.
  - If load_val==0: next state=EXPIRED, expired<=1 and tc<=1 on the next edge (immediate expiry, one-cycle latency).
  - en is ignored in the load cycle.
- IDLE: count holds; en and ack are ignored.
- RUN:
  - en=1 and count>1: count<=count-1.
  - en=1 and count==1: count<=0, state<=EXPIRED, tc<=1, expired<=1. bos=1 during this cycle.
  - en=0: everything holds.
  - Latency: load of N, with en held high, gives tc high exactly N cycles after the load edge.
- EXPIRED:
  - count holds at 0; expired=1.
  - ack=1 (with no load): state<=IDLE, expired<=0.
  - en is ignored.
- tc is high for exactly one cycle per expiry; it is never stretched by a held en.
- Decrement is modulo 2^WIDTH. Wrap below 0 is unreachable because RUN is never entered with count 0.
- Simultaneous events:
  - load+ack: load wins; expired cleared.
  - load during RUN: restart with the new value; no tc for the aborted run.
  - ack outside EXPIRED: no effect.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined: on the expiry step (RUN, en=1, count==1) and reload!=0:
  - count<=reload; state stays RUN; busy stays 1.
  - tc pulses and expired<=1 as normal.
  - ack clears expired without leaving RUN.
  - The block becomes a free-running divide-by-reload with a tc pulse every reload enabled cycles.
  - A load of 0 still goes to EXPIRED.
- Undefined: one-shot behaviour exactly as described in Behaviour.

Test Plan:
- clr asserted asynchronously mid-RUN (count=5): count=0, busy=0, tc=0 and expired=0 immediately, before the next edge.
- load=1, load_val=3, then en=1 held: count reads 3,2,1,0. bos=1 only in the cycle count==1. tc=1 for one cycle, 3 cycles after the load edge. expired stays 1 until ack, then state returns to IDLE.
- load_val=4 with en toggling 1,0,1,0,...: count decrements only on en=1 cycles. tc occurs after 4 enabled cycles (8 clocks). busy=1 throughout.
- load_val=0: next cycle tc=1 and expired=1, busy=0. load and ack in the same cycle with load_val=2: expired=0, state=RUN, count=2.
- Cascade: two instances, stage0.bos driving stage1.en, both loaded with 2, stage0 en=1 constant. Without the macro, stage1 decrements once when stage0 expires and never reaches 0. With COUNTDOWN_AUTO_RELOAD_EN, stage1 tc fires after 4 clocks.
- COUNTDOWN_AUTO_RELOAD_EN defined, load_val=3, en=1 for 10 cycles: tc pulses at cycles 3, 6 and 9; count sequence 3,2,1,3,2,1,...; busy stays 1.
